// File: rtl/ahb_sram_slave_pkg.sv
// ahb_sram_slave_pkg: AHB transfer codes shared with the CPU fetch master,
// the slave FSM state type and the little-endian byte-lane helper.
`timescale 1ns/1ps
package ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_e;

  // Lane enables for a transfer of the given size at byte offset lo.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lo;
      HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_bw_array.sv
// sram_bw_array: DEPTH_WORDS x 32 storage with per-byte write enables,
// synchronous write and registered read. A read and write to the same word
// on the same edge returns the old contents; the slave forwards around it.
// Ports: hclk_i, hresetn_i (clears only the read register), we/be/waddr/wdata
// write port, re/raddr read port, rdata registered read data.
`timescale 1ns/1ps
module sram_bw_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          hclk_i,
  input  logic          hresetn_i,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents survive reset on purpose.
  always_ff @(posedge hclk_i) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i)  rdata <= '0;
    else if (re)     rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB single-port SRAM slave with configurable wait states,
// two-cycle ERROR response for illegal transfers and read-after-write
// forwarding for an address phase overlapping a write data phase.
// Ports: hclk_i, hresetn_i; AHB slave inputs hsel_i, htrans_i, haddr_i,
// hwrite_i, hsize_i, hburst_i (ignored), hwdata_i, hready_i; outputs
// hreadyout_o, hresp_o, hrdata_o.
//
// state   | meaning
// IDLE    | ready; any pending legal data phase completes this cycle
// WAIT    | inserting wait cycles, hreadyout_o low
// ERR1    | first ERROR cycle, hreadyout_o low
// ERR2    | second ERROR cycle, hreadyout_o high, next address phase taken
`timescale 1ns/1ps
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic             hclk_i,
  input  logic             hresetn_i,
  input  logic             hsel_i,
  input  logic [1:0]       htrans_i,
  input  logic [WIDTH-1:0] haddr_i,
  input  logic             hwrite_i,
  input  logic [2:0]       hsize_i,
  input  logic [2:0]       hburst_i,
  input  logic [WIDTH-1:0] hwdata_i,
  input  logic             hready_i,
  output logic             hreadyout_o,
  output logic [1:0]       hresp_o,
  output logic [WIDTH-1:0] hrdata_o
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e          state_q, state_d;
  logic [3:0]      wait_cnt_q;
  logic            wr_pend_q;
  logic [AW-1:0]   dp_word_q;
  logic [3:0]      dp_be_q;
  logic [3:0]      fwd_be_q;
  logic [WIDTH-1:0] fwd_data_q;
  logic [WIDTH-1:0] arr_rdata;

  logic            ready_state, accept, size_ok, align_ok, range_ok, legal;
  logic            wr_commit, rd_req;
  logic [AW-1:0]   addr_word;
  logic [3:0]      addr_be;
  logic            unused_ok;

  // Bursts are handled beat by beat.
  assign unused_ok = ^hburst_i;

  assign ready_state = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign accept      = ready_state && hsel_i && hready_i &&
                       ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));

  assign size_ok  = (hsize_i <= HSIZE_WORD);
  assign range_ok = (haddr_i[WIDTH-1:AW+2] == '0);
  always_comb begin
    align_ok = 1'b1;
    case (hsize_i)
      HSIZE_HALF: align_ok = !haddr_i[0];
      HSIZE_WORD: align_ok = (haddr_i[1:0] == 2'b00);
      default:    align_ok = 1'b1;
    endcase
  end
  assign legal     = size_ok && align_ok && range_ok;
  assign addr_word = haddr_i[AW+1:2];
  assign addr_be   = byte_en(hsize_i, haddr_i[1:0]);

  // A pending write lands on the first edge where the slave is ready again.
  assign wr_commit = wr_pend_q && (state_q == ST_IDLE);
  assign rd_req    = accept && legal && !hwrite_i;

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (!accept)           state_d = ST_IDLE;
        else if (!legal)       state_d = ST_ERR1;
        else if (WS != 4'd0)   state_d = ST_WAIT;
        else                   state_d = ST_IDLE;
      end
      ST_WAIT: if (wait_cnt_q == 4'd1) state_d = ST_IDLE;
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    case (state_q)
      ST_WAIT: hreadyout_o = 1'b0;
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
      end
      ST_ERR2: hresp_o = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i)                 wait_cnt_q <= 4'd0;
    else if (accept && legal)       wait_cnt_q <= WS;
    else if (state_q == ST_WAIT)    wait_cnt_q <= wait_cnt_q - 4'd1;
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      wr_pend_q <= 1'b0;
      dp_word_q <= '0;
      dp_be_q   <= 4'b0000;
    end else if (accept) begin
      wr_pend_q <= legal && hwrite_i;
      dp_word_q <= addr_word;
      dp_be_q   <= addr_be;
    end else if (wr_commit) begin
      wr_pend_q <= 1'b0;
    end
  end

  // The array returns pre-write data when a read hits the word being written
  // on the same edge; remember which lanes to patch from hwdata_i.
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      fwd_be_q   <= 4'b0000;
      fwd_data_q <= '0;
    end else if (rd_req) begin
      fwd_be_q   <= (wr_commit && (dp_word_q == addr_word)) ? dp_be_q : 4'b0000;
      fwd_data_q <= hwdata_i;
    end
  end

  sram_bw_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .hclk_i   (hclk_i),
    .hresetn_i(hresetn_i),
    .we       (wr_commit),
    .be       (dp_be_q),
    .waddr    (dp_word_q),
    .wdata    (hwdata_i),
    .re       (rd_req),
    .raddr    (addr_word),
    .rdata    (arr_rdata)
  );

  always_comb begin
    hrdata_o = arr_rdata;
    for (int b = 0; b < 4; b++) begin
      if (fwd_be_q[b]) hrdata_o[8*b +: 8] = fwd_data_q[8*b +: 8];
    end
  end

endmodule
